// File: rtl/caixa_pkg.sv
// ---------------------------------------------------------------------------
// caixa_pkg
// Definitions shared by both ends of the water tank interface:
//   - level width and maximum, matching the fill-side level counter
//   - state encoding of the outlet controller (IDLE..ALARM)
//   - a small helper to size counters from a pair of parameters
// ---------------------------------------------------------------------------
package caixa_pkg;

    // The fill-side counter reports the tank level on 3 bits, 0..7.
    localparam int LEVEL_W   = 3;
    localparam int LEVEL_MAX = 7;

    // Outlet controller states. The numeric codes are visible on the debug
    // port, so they are pinned explicitly.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ASP    = 3'd1,
        GOT    = 3'd2,
        SWITCH = 3'd3,
        ALARM  = 3'd4
    } state_e;

    // Larger of two integers, used at elaboration time to size the shared
    // tick counter so it can hold either mode's period.
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/irrigacao_caixa_tick_div.sv
// ---------------------------------------------------------------------------
// tick_div
// Clear/enable modulo counter with a registered terminal-count pulse.
// The counter runs 0..term_i and wraps; the wrap cycle raises tc_o for
// exactly one cycle, visible after the edge on which the wrap happened.
//
// Ports:
//   clock     in   clock
//   reset     in   synchronous active-high reset
//   clear_i   in   restart the count at 0, drop any pending pulse
//   enable_i  in   advance the count this cycle
//   term_i    in   terminal value (modulus - 1), may change between uses
//   tc_o      out  one-cycle pulse after each wrap
// ---------------------------------------------------------------------------
module tick_div #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    // Next count and pulse. Clear has priority over enable so that a state
    // change on a terminal cycle never produces a pulse. The >= guards
    // against a count left above a smaller terminal after the modulus changed.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q >= term_i) begin
                cnt_d = '0;
                tc_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count and pulse registers; reset discards any partial count.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/irrigacao_caixa.sv
// ---------------------------------------------------------------------------
// irrigacao_caixa
// Outlet-side controller of the water tank. Watches the tank level from the
// fill-side counter and two soil sensors, opens the outlet valve in
// sprinkler (ASP) or drip (GOT) mode, and reports each consumed level unit
// with a one-cycle drain pulse so the fill side can keep its level model.
//
// Ports:
//   clock     in   clock
//   reset     in   synchronous active-high reset
//   count     in   tank level 0..7
//   Valve_E   in   fill valve state, informational only
//   soil_dry  in   soil-dry sensor
//   soil_wet  in   soil-wet sensor
//   Valve_S   out  outlet valve open (ASP or GOT)
//   asp       out  sprinkler mode active
//   got       out  drip mode active
//   drain     out  one-cycle pulse per consumed level unit
//   alarm     out  low-water alarm
//   fault     out  both soil sensors asserted (registered)
//   st        out  state code for debug
// ---------------------------------------------------------------------------
module irrigacao_caixa
    import caixa_pkg::*;
#(
    parameter int ASP_LEVEL = 3,
    parameter int MIN_LEVEL = 1,
    parameter int TICKS_ASP = 4,
    parameter int TICKS_GOT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] count,
    input  logic               Valve_E,
    input  logic               soil_dry,
    input  logic               soil_wet,
    output logic               Valve_S,
    output logic               asp,
    output logic               got,
    output logic               drain,
    output logic               alarm,
    output logic               fault,
    output logic [2:0]         st
);

    // Level thresholds compared one bit wider than the level itself so the
    // hysteresis threshold MIN_LEVEL+1 cannot wrap.
    localparam int HYST_LEVEL = MIN_LEVEL + 1;
    localparam logic [LEVEL_W:0] ASP_THR  = ASP_LEVEL[LEVEL_W:0];
    localparam logic [LEVEL_W:0] MIN_THR  = MIN_LEVEL[LEVEL_W:0];
    localparam logic [LEVEL_W:0] HYST_THR = HYST_LEVEL[LEVEL_W:0];

    // One counter serves both modes; it is sized for the longer period.
    localparam int TICK_W = $clog2(maxInt(TICKS_ASP, TICKS_GOT));
    localparam int TERM_ASP_I = TICKS_ASP - 1;
    localparam int TERM_GOT_I = TICKS_GOT - 1;
    localparam logic [TICK_W-1:0] TERM_ASP = TERM_ASP_I[TICK_W-1:0];
    localparam logic [TICK_W-1:0] TERM_GOT = TERM_GOT_I[TICK_W-1:0];

    state_e              state_q, state_d;
    logic                fault_q, fault_d;
    logic                dry;
    logic                levelEmpty;
    logic                levelAsp;
    logic                levelMin;
    logic                levelHyst;
    logic [LEVEL_W:0]    countExt;
    logic                inMode;
    logic                tickClear;
    logic                tickEnable;
    logic [TICK_W-1:0]   tickTerm;
    logic                tickPulse;
    logic                unusedValveE;

    // The fill valve is reported for visibility but never gates the outlet.
    assign unusedValveE = Valve_E;

    // A sensor fault (both high) is not "dry", so an active mode ends as if
    // the soil were wet and no alarm is raised.
    assign dry        = soil_dry & ~soil_wet;
    assign countExt   = {1'b0, count};
    assign levelEmpty = (count == '0);
    assign levelAsp   = (countExt >= ASP_THR);
    assign levelMin   = (countExt >= MIN_THR) && !levelEmpty;
    assign levelHyst  = (countExt >= HYST_THR);

    // Next-state logic. An empty tank with dry soil always lands in ALARM,
    // whatever MIN_LEVEL is set to. In ASP, wet soil is checked before the
    // level so that a simultaneous drop goes straight to IDLE. GOT never
    // upgrades to ASP directly; a refill only takes effect via IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dry) begin
                    if (levelEmpty) begin
                        state_d = ALARM;
                    end else if (levelAsp) begin
                        state_d = ASP;
                    end else if (levelMin) begin
                        state_d = GOT;
                    end else begin
                        state_d = ALARM;
                    end
                end
            end
            ASP: begin
                if (!dry) begin
                    state_d = IDLE;
                end else if (!levelAsp || levelEmpty) begin
                    state_d = SWITCH;
                end
            end
            GOT: begin
                if (!dry) begin
                    state_d = IDLE;
                end else if (!levelMin) begin
                    state_d = ALARM;
                end
            end
            SWITCH: begin
                if (levelMin) begin
                    state_d = GOT;
                end else begin
                    state_d = ALARM;
                end
            end
            ALARM: begin
                if (levelHyst || !dry) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The sensor fault flag simply follows the sensors one cycle late.
    always_comb begin
        fault_d = soil_dry & soil_wet;
    end

    // State and fault registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    // The tick counter restarts on every state change and only advances
    // while a mode persists, so a mode exit on the terminal cycle never
    // produces a drain pulse.
    assign inMode     = (state_q == ASP) || (state_q == GOT);
    assign tickClear  = (state_d != state_q);
    assign tickEnable = inMode && (state_d == state_q);
    assign tickTerm   = (state_q == ASP) ? TERM_ASP : TERM_GOT;

    tick_div #(
        .WIDTH (TICK_W)
    ) u_tick_div (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (tickClear),
        .enable_i (tickEnable),
        .term_i   (tickTerm),
        .tc_o     (tickPulse)
    );

    // Moore output decode from the registered state.
    assign Valve_S = inMode;
    assign asp     = (state_q == ASP);
    assign got     = (state_q == GOT);
    assign alarm   = (state_q == ALARM);
    assign drain   = tickPulse;
    assign fault   = fault_q;
    assign st      = state_q;

endmodule

// File: tb/tb_irrigacao_caixa.sv
// ---------------------------------------------------------------------------
// tb_irrigacao_caixa
// Scenario bench for the outlet controller with default parameters.
// Expected output vectors are written into a queue before each clock step
// and popped and compared once the step has completed.
// Output vector layout: {Valve_S, asp, got, drain, alarm, fault, st[2:0]}.
// ---------------------------------------------------------------------------
module tb_irrigacao_caixa;

    typedef struct {
        string      name;
        logic [8:0] val;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [2:0] count;
    logic       Valve_E;
    logic       soil_dry;
    logic       soil_wet;
    logic       Valve_S;
    logic       asp;
    logic       got;
    logic       drain;
    logic       alarm;
    logic       fault;
    logic [2:0] st;
    logic [8:0] obs;

    exp_t expQ[$];
    exp_t e;
    int   checks;
    int   failures;

    irrigacao_caixa dut (
        .clock    (clock),
        .reset    (reset),
        .count    (count),
        .Valve_E  (Valve_E),
        .soil_dry (soil_dry),
        .soil_wet (soil_wet),
        .Valve_S  (Valve_S),
        .asp      (asp),
        .got      (got),
        .drain    (drain),
        .alarm    (alarm),
        .fault    (fault),
        .st       (st)
    );

    assign obs = {Valve_S, asp, got, drain, alarm, fault, st};

    // 10 time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Build an expected vector from individual output values.
    function automatic logic [8:0] mk(input logic v, input logic a, input logic g,
                                      input logic d, input logic al, input logic f,
                                      input logic [2:0] s);
        return {v, a, g, d, al, f, s};
    endfunction

    // Drive one cycle of inputs, clock it, and settle 1 unit past the edge.
    // Valve_E is randomised to show it has no influence.
    task automatic applyStimulus(input logic rst, input logic [2:0] cnt,
                                 input logic dryIn, input logic wetIn);
        reset    = rst;
        count    = cnt;
        soil_dry = dryIn;
        soil_wet = wetIn;
        Valve_E  = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        expQ.push_back('{"reset0", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"reset1", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"idle_not_dry", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd7, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
    endtask

    task automatic test_sprinkler_drain();
        expQ.push_back('{"asp_entry", mk(1,1,0,0,0,0,3'd1)});
        applyStimulus(1'b0, 3'd5, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        for (int k = 1; k <= 12; k++) begin
            expQ.push_back('{$sformatf("asp_tick%0d", k), mk(1,1,0,(k % 4 == 0),0,0,3'd1)});
            applyStimulus(1'b0, 3'd5, 1'b1, 1'b0);
            e = expQ.pop_front(); checks++;
            if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        end
        expQ.push_back('{"asp_wet_exit", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd5, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
    endtask

    task automatic test_handover();
        expQ.push_back('{"ho_asp", mk(1,1,0,0,0,0,3'd1)});
        applyStimulus(1'b0, 3'd5, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        for (int k = 1; k <= 2; k++) begin
            expQ.push_back('{$sformatf("ho_asp_tick%0d", k), mk(1,1,0,0,0,0,3'd1)});
            applyStimulus(1'b0, 3'd5, 1'b1, 1'b0);
            e = expQ.pop_front(); checks++;
            if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        end
        expQ.push_back('{"ho_switch", mk(0,0,0,0,0,0,3'd3)});
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"ho_got", mk(1,0,1,0,0,0,3'd2)});
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        for (int k = 1; k <= 16; k++) begin
            expQ.push_back('{$sformatf("got_tick%0d", k), mk(1,0,1,(k % 8 == 0),0,0,3'd2)});
            applyStimulus(1'b0, 3'd2, 1'b1, 1'b0);
            e = expQ.pop_front(); checks++;
            if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        end
        expQ.push_back('{"ho_exit", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
    endtask

    task automatic test_exit_priority();
        expQ.push_back('{"pr_asp", mk(1,1,0,0,0,0,3'd1)});
        applyStimulus(1'b0, 3'd6, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"pr_wet_and_drop", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"pr_stay_idle", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
    endtask

    task automatic test_thresholds();
        expQ.push_back('{"thr_asp_at3", mk(1,1,0,0,0,0,3'd1)});
        applyStimulus(1'b0, 3'd3, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"thr_idle_a", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd3, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"thr_got_at1", mk(1,0,1,0,0,0,3'd2)});
        applyStimulus(1'b0, 3'd1, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"thr_idle_b", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"thr_fault_idle", mk(0,0,0,0,0,1,3'd0)});
        applyStimulus(1'b0, 3'd7, 1'b1, 1'b1);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"thr_fault_clear", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd7, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
    endtask

    task automatic test_alarm();
        expQ.push_back('{"al_enter", mk(0,0,0,0,1,0,3'd4)});
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        for (int k = 0; k < 2; k++) begin
            expQ.push_back('{$sformatf("al_hold_lvl1_%0d", k), mk(0,0,0,0,1,0,3'd4)});
            applyStimulus(1'b0, 3'd1, 1'b1, 1'b0);
            e = expQ.pop_front(); checks++;
            if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        end
        expQ.push_back('{"al_hyst_exit", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"al_then_got", mk(1,0,1,0,0,0,3'd2)});
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"al_got_to_alarm", mk(0,0,0,0,1,0,3'd4)});
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"al_wet_exit", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
    endtask

    task automatic test_sensor_fault();
        expQ.push_back('{"sf_got", mk(1,0,1,0,0,0,3'd2)});
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        for (int k = 1; k <= 7; k++) begin
            expQ.push_back('{$sformatf("sf_tick%0d", k), mk(1,0,1,0,0,0,3'd2)});
            applyStimulus(1'b0, 3'd2, 1'b1, 1'b0);
            e = expQ.pop_front(); checks++;
            if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        end
        expQ.push_back('{"sf_fault_exit", mk(0,0,0,0,0,1,3'd0)});
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b1);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"sf_clear", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
    endtask

    task automatic test_reset_mid();
        expQ.push_back('{"rm_asp", mk(1,1,0,0,0,0,3'd1)});
        applyStimulus(1'b0, 3'd5, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        for (int k = 1; k <= 3; k++) begin
            expQ.push_back('{$sformatf("rm_tick%0d", k), mk(1,1,0,0,0,0,3'd1)});
            applyStimulus(1'b0, 3'd5, 1'b1, 1'b0);
            e = expQ.pop_front(); checks++;
            if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        end
        expQ.push_back('{"rm_reset", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        expQ.push_back('{"rm_reenter", mk(1,1,0,0,0,0,3'd1)});
        applyStimulus(1'b0, 3'd5, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        for (int k = 1; k <= 4; k++) begin
            expQ.push_back('{$sformatf("rm_retick%0d", k), mk(1,1,0,(k == 4),0,0,3'd1)});
            applyStimulus(1'b0, 3'd5, 1'b1, 1'b0);
            e = expQ.pop_front(); checks++;
            if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        end
        expQ.push_back('{"rm_exit", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd5, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
    endtask

    task automatic test_no_upgrade();
        expQ.push_back('{"nu_got", mk(1,0,1,0,0,0,3'd2)});
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        for (int k = 1; k <= 9; k++) begin
            expQ.push_back('{$sformatf("nu_full%0d", k), mk(1,0,1,(k == 8),0,0,3'd2)});
            applyStimulus(1'b0, 3'd7, 1'b1, 1'b0);
            e = expQ.pop_front(); checks++;
            if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
        end
        expQ.push_back('{"nu_exit", mk(0,0,0,0,0,0,3'd0)});
        applyStimulus(1'b0, 3'd7, 1'b0, 1'b0);
        e = expQ.pop_front(); checks++;
        if (obs !== e.val) begin failures++; $display("[TB] FAIL %s: got %b expected %b", e.name, obs, e.val); end
    endtask

    // Scenario sequence; each scenario starts and ends in IDLE.
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        count    = 3'd0;
        Valve_E  = 1'b0;
        soil_dry = 1'b0;
        soil_wet = 1'b0;
        $display("[TB] starting irrigacao_caixa scenarios");
        test_reset();
        test_sprinkler_drain();
        test_handover();
        test_exit_priority();
        test_thresholds();
        test_alarm();
        test_sensor_fault();
        test_reset_mid();
        test_no_upgrade();
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
